axi4_lite_master_arb2: RTL
==========================

Name: axi4_lite_master_arb2

Overview:
- Two-requester AXI4-Lite master that shares one AXI4-Lite slave port (e.g. the GPIO register slave) between two simple request/done clients, such as the CPU bus bridge and a DMA/test sequencer.
- Performs round-robin arbitration and converts each granted request into a complete AXI4-Lite write (AW+W+B) or read (AR+R) transaction.
- Returns read data and a per-transaction error flag to the owning requester.
- Exactly one transaction is outstanding at a time.

Parameters:
- ADDR_W, 4, AXI and requester address width.
- DATA_W, 32, AXI and requester data width.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- req  in  2  request per requester; held high until done.
- we  in  2  1 = write, 0 = read; per requester.
- addr  in  2*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W].
- wdata  in  2*DATA_W  requester i write data at [i*DATA_W +: DATA_W].
- gnt  out  2  one-hot current owner; 0 when idle.
- done  out  2  one-cycle pulse to the owner at transaction end.
- err  out  1  valid with done; 1 if BRESP/RRESP[1] was set (SLVERR/DECERR).
- rdata  out  DATA_W  read data; valid with done on reads; holds until next read completes.
- AWADDR  out  ADDR_W, AWVALID  out  1, AWREADY  in  1: write address channel.
- WDATA  out  DATA_W, WVALID  out  1, WREADY  in  1: write data channel.
- BRESP  in  2, BVALID  in  1, BREADY  out  1: write response channel.
- ARADDR  out  ADDR_W, ARVALID  out  1, ARREADY  in  1: read address channel.
- RDATA  in  DATA_W, RRESP  in  2, RVALID  in  1, RREADY  out  1: read data channel.

Behaviour:
- Reset (ARESET=1 at a clock edge):
  - state=IDLE.
  - All VALID/READY outputs, gnt, done, err, and rdata are 0.
  - last_grant=1, so requester 0 wins the first tie.
  - A reset mid-transaction abandons the transaction immediately. No done is issued. The slave is reset in the same domain.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - req sampled only here.
  - Only one req high: that requester wins.
  - Both req high: winner = ~last_grant.
  - On a win: latch owner, we, addr, wdata into internal registers; set gnt; update last_grant := owner.
  - Next state: WR_REQ if we[owner], else RD_REQ.
  - Requester inputs are ignored after latching; deasserting req mid-transaction does not abort.
- WR_REQ:
  - AWVALID=~aw_done, WVALID=~w_done, both from the cycle after the grant.
  - AWADDR and WDATA come from the latched registers and are stable until their handshake.
  - aw_done/w_done set on their own VALID&&READY. Either order is legal; both handshaking in the same cycle is legal.
  - When both are done (including the same cycle), go to WR_RESP.
  - No VALID ever drops before its READY.
- WR_RESP: BREADY=1. On BVALID: capture err_r=BRESP[1], then go to DONE.
- RD_REQ: ARVALID=1 with ARADDR latched. On ARREADY, go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID: rdata_r<=RDATA, err_r=RRESP[1], then go to DONE.
- DONE:
  - done[owner]=1 for exactly one cycle; err valid.
  - gnt stays asserted in DONE and clears on return to IDLE.
  - Next state: IDLE.
  - The requester must have req low in the cycle after done, otherwise that cycle is a new request.
- Latency, with a zero-wait slave: grant edge → VALIDs next cycle.
  - Write: IDLE, WR_REQ, WR_RESP, DONE = 4 cycles from req to done.
  - Read: 4 cycles as well.
  - Each slave wait cycle adds 1.
- Fairness: with both req held continuously, grants alternate 0,1,0,1. No starvation.
- No timeout. A slave that never responds hangs the FSM until reset (documented limitation).

Decomposition:
- Shared package axi4_lite_pkg holds:
  - the resp_e enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the master FSM state enum;
  - ADDR_W/DATA_W defaults.
- Sub-module rr_arb2: combinational 2-way round-robin. Inputs req[1:0] and last_grant; outputs one-hot winner. Reused by later multi-master blocks.

Test Plan:
- Single write: req=2'b01, we[0]=1, addr0=4'h4, wdata0=32'h0000_00A5; slave readies after 2 cycles → AWADDR=4'h4 and WDATA=32'hA5 held until READY, BREADY seen, done=2'b01, err=0, slave reg1=8'hA5.
- Single read: req=2'b10, we[1]=0, addr1=4'h8; slave returns RDATA=32'h0000_003C, RRESP=OKAY → done=2'b10, rdata=32'h3C, err=0. No AW/W activity.
- Contention: both req high from reset, requester 0 writing and requester 1 reading, held for 4 transactions → grant order 0,1,0,1; gnt one-hot throughout; never more than one transaction on AXI.
- Channel skew: slave asserts WREADY 3 cycles before AWREADY, then with AWREADY and WREADY in the same cycle → each VALID drops only after its own handshake; exactly one B accepted; one done.
- Error response: slave returns BRESP=2'b10, then a read with RRESP=2'b11 → err=1 with each done; rdata updated to the returned RDATA for the read.
- Reset mid-transaction: ARESET pulsed while in WR_RESP → next cycle all outputs 0, state IDLE, no done pulse. A following req=2'b11 is granted to requester 0 first.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, master FSM states and default widths.
package axi4_lite_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StDone
  } mst_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter; a tie goes to the requester not granted last.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] winner_o
);

  always_comb begin
    winner_o = 2'b00;
    unique case (req_i)
      2'b01:   winner_o = 2'b01;
      2'b10:   winner_o = 2'b10;
      2'b11:   winner_o = last_grant_i ? 2'b01 : 2'b10;
      default: winner_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi4_lite_master_arb2.sv
// Two-requester AXI4-Lite master: round-robin grant, one outstanding transaction,
// read data and error flag returned to the owning requester.
module axi4_lite_master_arb2
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY
);

  mst_state_e        state_q;
  logic              last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_done_q;
  logic              w_done_q;
  logic [1:0]        winner;
  logic              win_idx;

  rr_arb2 u_rr_arb2 (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .winner_o     (winner)
  );

  assign win_idx = winner[1];
  assign AWADDR  = addr_q;
  assign ARADDR  = addr_q;
  assign WDATA   = wdata_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      gnt          <= 2'b00;
      done         <= 2'b00;
      err          <= 1'b0;
      rdata        <= '0;
      AWVALID      <= 1'b0;
      WVALID       <= 1'b0;
      BREADY       <= 1'b0;
      ARVALID      <= 1'b0;
      RREADY       <= 1'b0;
    end else begin
      done <= 2'b00;
      unique case (state_q)
        StIdle: begin
          if (winner != 2'b00) begin
            addr_q       <= addr[win_idx*ADDR_W +: ADDR_W];
            wdata_q      <= wdata[win_idx*DATA_W +: DATA_W];
            gnt          <= winner;
            last_grant_q <= win_idx;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            if (we[win_idx]) begin
              state_q <= StWrReq;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
            end else begin
              state_q <= StRdReq;
              ARVALID <= 1'b1;
            end
          end
        end
        StWrReq: begin
          if (AWVALID && AWREADY) begin
            AWVALID   <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (WVALID && WREADY) begin
            WVALID   <= 1'b0;
            w_done_q <= 1'b1;
          end
          // Address and data may complete in either order or together.
          if ((aw_done_q || (AWVALID && AWREADY)) && (w_done_q || (WVALID && WREADY))) begin
            state_q <= StWrResp;
            BREADY  <= 1'b1;
          end
        end
        StWrResp: begin
          if (BVALID) begin
            err     <= BRESP[1];
            BREADY  <= 1'b0;
            done    <= gnt;
            state_q <= StDone;
          end
        end
        StRdReq: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state_q <= StRdResp;
          end
        end
        StRdResp: begin
          if (RVALID) begin
            rdata   <= RDATA;
            err     <= RRESP[1];
            RREADY  <= 1'b0;
            done    <= gnt;
            state_q <= StDone;
          end
        end
        StDone: begin
          gnt     <= 2'b00;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
